// File: rtl/tproc_isa_pkg.sv
// Shared ISA definitions for the accelerator instruction processor:
// opcodes, engine unit codes and the dispatch sequencer state encoding.
package tproc_isa_pkg;

   localparam logic [3:0] OPC_NOP    = 4'h0;
   localparam logic [3:0] OPC_LOAD_F = 4'h1;
   localparam logic [3:0] OPC_LOAD_W = 4'h2;
   localparam logic [3:0] OPC_COMP   = 4'h3;
   localparam logic [3:0] OPC_STORE  = 4'h4;
   localparam logic [3:0] OPC_END    = 4'hF;

   localparam logic [1:0] UNIT_LOAD_F = 2'd0;
   localparam logic [1:0] UNIT_LOAD_W = 2'd1;
   localparam logic [1:0] UNIT_COMP   = 2'd2;
   localparam logic [1:0] UNIT_STORE  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_FINISH = 3'd3,
      ST_ERROR  = 3'd4
   } dispatch_state_t;

   function automatic logic opc_is_issuable(input logic [3:0] opc);
      return (opc == OPC_LOAD_F) || (opc == OPC_LOAD_W) ||
             (opc == OPC_COMP)   || (opc == OPC_STORE);
   endfunction

   function automatic logic [1:0] opc_to_unit(input logic [3:0] opc);
      logic [1:0] unit;
      unit = UNIT_LOAD_F;
      case (opc)
         OPC_LOAD_W: unit = UNIT_LOAD_W;
         OPC_COMP:   unit = UNIT_COMP;
         OPC_STORE:  unit = UNIT_STORE;
         default:    unit = UNIT_LOAD_F;
      endcase
      return unit;
   endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Small synchronous prefetch FIFO with a register-file store; the head entry
// is always visible from registers, so dispatch sees it with no read latency.
module instr_prefetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (PW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entries are cleared on reset so the head reads as zero out of reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               mem_reg[gi] <= '0;
            end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
               mem_reg[gi] <= push_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/instr_dispatch_ctrl.sv
// Instruction fetch/dispatch sequencer: prefetches program words, issues them
// to the load/compute/store engines. Optional counters via INSTR_DISPATCH_PERF_EN.
module instr_dispatch_ctrl
   import tproc_isa_pkg::*;
#(
   parameter int INSTR_WIDTH = 64,
   parameter int ADDR_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   acc_enable,
   input  logic [INSTR_WIDTH-1:0] instr_port,
   output logic [ADDR_WIDTH-1:0]  instr_fetch_addr,
   output logic                   instr_rd_en,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [INSTR_WIDTH-1:0] issue_instr,
   output logic [1:0]             issue_unit,
   output logic                   busy,
   output logic                   done,
   output logic                   err
`ifdef INSTR_DISPATCH_PERF_EN
   ,
   output logic [31:0]            perf_cycles,
   output logic [31:0]            perf_stall
`endif
);

   dispatch_state_t state_reg, state_next;

   logic [ADDR_WIDTH-1:0]  fetch_ptr_reg;
   logic                   err_reg;
   logic [INSTR_WIDTH-1:0] fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic                   fifo_push;
   logic [3:0]             fetch_opc;
   logic [3:0]             head_opc;
   logic                   fetch_is_end;
   logic                   fetch_is_illegal;
   logic                   fetch_at_last;
   logic                   dispatching;
   logic                   start;

   assign fetch_opc        = instr_port[INSTR_WIDTH-1 -: 4];
   assign head_opc         = fifo_head[INSTR_WIDTH-1 -: 4];
   assign fetch_is_end     = (fetch_opc == OPC_END);
   assign fetch_is_illegal = !(fetch_is_end || (fetch_opc == OPC_NOP) || opc_is_issuable(fetch_opc));
   assign fetch_at_last    = (fetch_ptr_reg == {ADDR_WIDTH{1'b1}});
   assign fifo_push        = instr_rd_en && !fetch_is_end && !fetch_is_illegal;
   assign start            = (state_reg == ST_IDLE) && acc_enable;

   instr_prefetch_fifo #(
      .WIDTH (INSTR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (instr_port),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (acc_enable) state_next = ST_RUN;
         ST_RUN:    if (instr_rd_en && (fetch_is_end || fetch_is_illegal || fetch_at_last))
                       state_next = ST_DRAIN;
         ST_DRAIN:  if (fifo_empty) state_next = err_reg ? ST_ERROR : ST_FINISH;
         ST_FINISH: state_next = ST_IDLE;
         ST_ERROR:  state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Fullness is judged at the start of the cycle, so a same-cycle pop
   // cannot make room for a fetch.
   always_comb begin
      dispatching = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
      instr_rd_en = (state_reg == ST_RUN) && !fifo_full;
      issue_valid = dispatching && !fifo_empty && (head_opc != OPC_NOP);
      fifo_pop    = dispatching && !fifo_empty && ((head_opc == OPC_NOP) || issue_ready);
      busy        = (state_reg != ST_IDLE);
      done        = (state_reg == ST_FINISH);
   end

   // The pointer parks on the last address instead of wrapping to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_ptr_reg <= '0;
         err_reg       <= 1'b0;
      end else if (start) begin
         fetch_ptr_reg <= '0;
         err_reg       <= 1'b0;
      end else if (instr_rd_en) begin
         if (fifo_push && !fetch_at_last) fetch_ptr_reg <= fetch_ptr_reg + 1'b1;
         if (fetch_is_illegal || (fetch_at_last && !fetch_is_end)) err_reg <= 1'b1;
      end
   end

   assign instr_fetch_addr = fetch_ptr_reg;
   assign issue_instr      = fifo_head;
   assign issue_unit       = opc_to_unit(head_opc);
   assign err              = err_reg;

`ifdef INSTR_DISPATCH_PERF_EN
   logic [31:0] perf_cycles_reg;
   logic [31:0] perf_stall_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles_reg <= '0;
         perf_stall_reg  <= '0;
      end else if (start) begin
         perf_cycles_reg <= '0;
         perf_stall_reg  <= '0;
      end else if (busy) begin
         if (perf_cycles_reg != '1) perf_cycles_reg <= perf_cycles_reg + 1'b1;
         if (issue_valid && !issue_ready && (perf_stall_reg != '1))
            perf_stall_reg <= perf_stall_reg + 1'b1;
      end
   end

   assign perf_cycles = perf_cycles_reg;
   assign perf_stall  = perf_stall_reg;
`endif

endmodule
